// File: rtl/seven_seg_capture_if.sv
// Display bus between a multiplexed four-digit seven-segment driver and
// anything watching it. Both lines are active low.
//   an  [3:0] : anode enables, an[0]=digit D ... an[3]=digit A
//   seg [6:0] : cathodes {g,f,e,d,c,b,a}
// master = driver side, slave = receiver/monitor side.
interface seven_seg_capture_if;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (output an, seg);
  modport slave  (input  an, seg);
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment display. Resynchronizes the
// anode/cathode lines, waits for them to sit still, and rebuilds the four
// displayed hex nibbles plus status.
// Ports:
//   clk_25MHz, reset_n : clock, async active-low reset
//   disp               : display bus (slave modport: an, seg)
//   err_clear          : one-cycle pulse, clears the sticky error flags
//   displayD..displayA : last accepted nibble of digits 0..3
//   digit_valid        : digit i accepted with a legal hex pattern since last timeout
//   digit_blank        : digit i's last accepted pattern was all-off
//   frame_done         : pulse when all four digits seen since the previous pulse
//   timeout            : pulse every TIMEOUT_CYCLES without a digit event
//   an_err, pattern_err: sticky protocol errors

// Per-digit state: nibble, valid and blank flags.
module seven_seg_capture_lane (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic       hit,     // digit event (legal or blank) addressed to this lane
  input  logic       legal,
  input  logic       blank,
  input  logic       tmo,     // timeout this cycle (never together with a hit)
  input  logic [3:0] nibble,
  output logic [3:0] disp,
  output logic       valid,
  output logic       blank_f
);
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      disp    <= 4'h0;
      valid   <= 1'b0;
      blank_f <= 1'b0;
    end else if (hit) begin
      if (legal) begin
        disp    <= nibble;
        valid   <= 1'b1;
        blank_f <= 1'b0;
      end else if (blank) begin
        blank_f <= 1'b1;
      end
    end else if (tmo) begin
      valid <= 1'b0;
    end
  end
endmodule

module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic                  clk_25MHz,
  input  logic                  reset_n,
  seven_seg_capture_if.slave    disp,
  input  logic                  err_clear,
  output logic [3:0]            displayD,
  output logic [3:0]            displayC,
  output logic [3:0]            displayB,
  output logic [3:0]            displayA,
  output logic [3:0]            digit_valid,
  output logic [3:0]            digit_blank,
  output logic                  frame_done,
  output logic                  timeout,
  output logic                  an_err,
  output logic                  pattern_err
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [10:0]      sync1, sync2;
  logic [SW-1:0]    stab_cnt;
  logic [CNT_W-1:0] tcnt;
  logic [3:0]       seen;

  // Two-flop synchronizer, idle (all ones) out of reset.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {disp.an, disp.seg};
      sync2 <= sync1;
    end
  end

  // Stability is judged on the value about to enter stage 2 against the one
  // already there, so the count and the accept decision land on the same
  // edge as the registered outputs: a held input shows up 2+STABLE_CYCLES
  // edges after it first appears.
  logic same, accept;
  assign same   = (sync1 == sync2);
  assign accept = same && (stab_cnt == SW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n)                               stab_cnt <= '0;
    else if (!same)                             stab_cnt <= '0;
    else if (stab_cnt != SW'(STABLE_CYCLES))    stab_cnt <= stab_cnt + SW'(1);
  end

  // Classification of the accepted value.
  logic [3:0] an_s, an_low;
  logic [6:0] seg_s;
  logic       single, multi;
  assign an_s   = sync2[10:7];
  assign seg_s  = sync2[6:0];
  assign an_low = ~an_s;
  assign single = (an_low != 4'b0) && ((an_low & (an_low - 4'd1)) == 4'b0);
  assign multi  = (an_low != 4'b0) && !single;

  logic       legal, blank;
  logic [3:0] nibble;
  assign blank = (seg_s == 7'b1111111);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg_s)
      7'b1000000: nibble = 4'h0;
      7'b1111001: nibble = 4'h1;
      7'b0100100: nibble = 4'h2;
      7'b0110000: nibble = 4'h3;
      7'b0011001: nibble = 4'h4;
      7'b0010010: nibble = 4'h5;
      7'b0000010: nibble = 4'h6;
      7'b1111000: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0010000: nibble = 4'h9;
      7'b0001000: nibble = 4'hA;
      7'b0000011: nibble = 4'hB;
      7'b1000110: nibble = 4'hC;
      7'b0100001: nibble = 4'hD;
      7'b0000110: nibble = 4'hE;
      7'b0001110: nibble = 4'hF;
      default:    legal  = 1'b0;
    endcase
  end

  logic       digit_ev, new_an_err, new_pat_err, tmo_hit;
  logic [3:0] lane_hit, seen_nxt;
  assign digit_ev    = accept && single && (legal || blank);
  assign lane_hit    = digit_ev ? an_low : 4'b0;
  assign new_an_err  = accept && multi;
  assign new_pat_err = accept && single && !legal && !blank;
  // A digit event in the same cycle pre-empts the timeout.
  assign tmo_hit     = !digit_ev && (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign seen_nxt    = seen | an_low;

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      tcnt        <= '0;
      seen        <= 4'b0;
      frame_done  <= 1'b0;
      timeout     <= 1'b0;
      an_err      <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= tmo_hit;

      if (digit_ev || tmo_hit) tcnt <= '0;
      else                     tcnt <= tcnt + CNT_W'(1);

      if (digit_ev) begin
        if (seen_nxt == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= 4'b0;
        end else begin
          seen       <= seen_nxt;
        end
      end else if (tmo_hit) begin
        seen <= 4'b0;
      end

      // New error beats a simultaneous clear.
      an_err      <= new_an_err  | (an_err      & ~err_clear);
      pattern_err <= new_pat_err | (pattern_err & ~err_clear);
    end
  end

  logic [3:0][3:0] lane_disp;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    seven_seg_capture_lane u_lane (
      .clk_25MHz (clk_25MHz),
      .reset_n   (reset_n),
      .hit       (lane_hit[i]),
      .legal     (legal),
      .blank     (blank),
      .tmo       (tmo_hit),
      .nibble    (nibble),
      .disp      (lane_disp[i]),
      .valid     (digit_valid[i]),
      .blank_f   (digit_blank[i])
    );
  end

  assign displayD = lane_disp[0];
  assign displayC = lane_disp[1];
  assign displayB = lane_disp[2];
  assign displayA = lane_disp[3];
endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed steps plus a randomized phase, every
// cycle compared against a behavioural model of the display receiver.
module tb_seven_seg_capture;
  localparam int STABLE = 16;
  localparam int TMO    = 300;
  localparam int CW     = 9;

  logic       clk_25MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       err_clear = 1'b0;
  logic [3:0] displayD, displayC, displayB, displayA;
  logic [3:0] digit_valid, digit_blank;
  logic       frame_done, timeout, an_err, pattern_err;

  seven_seg_capture_if bus();

  seven_seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk_25MHz   (clk_25MHz),
    .reset_n     (reset_n),
    .disp        (bus.slave),
    .err_clear   (err_clear),
    .displayD    (displayD),
    .displayC    (displayC),
    .displayB    (displayB),
    .displayA    (displayA),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .frame_done  (frame_done),
    .timeout     (timeout),
    .an_err      (an_err),
    .pattern_err (pattern_err)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  logic [6:0] hex_pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_assert = 0;
  int n_fail   = 0;

  logic [27:0] dut_vec;
  assign dut_vec = {displayA, displayB, displayC, displayD, digit_valid, digit_blank,
                    frame_done, timeout, an_err, pattern_err};

  // Reference model state
  logic [3:0]  m_disp [4];
  logic [3:0]  m_valid, m_blank, m_seen;
  logic        m_frame, m_tmo, m_aerr, m_perr;
  int          edge_n, last_mark, run;
  logic [10:0] run_val;
  // Observation bookkeeping
  int          cyc, frames, tmos, tmo_at [$];

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (hex_pat[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [27:0] m_vec();
    return {m_disp[3], m_disp[2], m_disp[1], m_disp[0], m_valid, m_blank,
            m_frame, m_tmo, m_aerr, m_perr};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_disp[i] = 4'h0;
    m_valid = 0; m_blank = 0; m_seen = 0;
    m_frame = 0; m_tmo = 0; m_aerr = 0; m_perr = 0;
    edge_n = 0; last_mark = 0; run = 0; run_val = '1;
  endtask

  // One clock edge of the model. A value present on the lines for
  // STABLE+1 consecutive edges is acted on at the following edge, once.
  task automatic m_edge();
    logic [3:0]  lo;
    logic [10:0] cur;
    bit          ev, na, np;
    int          idx, nib;
    edge_n++;
    ev = 0; na = 0; np = 0; idx = 0;
    m_frame = 0; m_tmo = 0;
    if (run == STABLE + 1) begin
      lo = ~run_val[10:7];
      if ($countones(lo) > 1) na = 1;
      else if ($countones(lo) == 1) begin
        for (int i = 0; i < 4; i++) if (lo[i]) idx = i;
        nib = decode(run_val[6:0]);
        if (nib >= 0) begin
          m_disp[idx] = nib[3:0]; m_valid[idx] = 1; m_blank[idx] = 0; ev = 1;
        end else if (run_val[6:0] == 7'h7F) begin
          m_blank[idx] = 1; ev = 1;
        end else np = 1;
      end
    end
    if (ev) begin
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin m_frame = 1; m_seen = 0; end
      last_mark = edge_n;
    end else if (edge_n - last_mark == TMO) begin
      m_tmo = 1; m_valid = 0; m_seen = 0; last_mark = edge_n;
    end
    m_aerr = na | (m_aerr & ~err_clear);
    m_perr = np | (m_perr & ~err_clear);
    cur = {bus.an, bus.seg};
    if (cur == run_val) begin if (run < 1000) run++; end
    else begin run_val = cur; run = 1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk_25MHz);
    m_edge();
    @(negedge clk_25MHz);
    cyc++;
    if (frame_done) frames++;
    if (timeout) begin tmos++; tmo_at.push_back(cyc); end
    chk(tag, {4'b0, dut_vec}, {4'b0, m_vec()});
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input string tag);
    bus.an = a; bus.seg = s;
    repeat (n) tick(tag);
  endtask

  initial begin
    logic [3:0]  ra, pa;
    logic [6:0]  rs, ps;
    logic [3:0]  dig [4];
    int          f0, t0, k;

    cyc = 0; frames = 0; tmos = 0;
    bus.an = 4'hF; bus.seg = 7'h7F;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk_25MHz);
    chk("reset_state", {4'b0, dut_vec}, 32'h0);
    reset_n = 1'b1;
    m_reset();

    // First capture: digit D = 5 appears exactly at edge 18
    hold(4'b1110, 7'b0010010, 17, "capture5");
    chk("before_latency", {28'h0, displayD}, 32'h0);
    tick("capture5");
    chk("latency_dispD", {28'h0, displayD}, 32'h5);
    chk("latency_valid", {28'h0, digit_valid}, 32'h1);
    hold(4'b1110, 7'b0010010, 2, "capture5");

    // Two anodes low -> an_err, then clear
    hold(4'b1100, 7'b1111001, 20, "an_err");
    chk("an_err_set", {31'h0, an_err}, 32'h1);
    chk("an_err_nochange", {28'h0, displayD}, 32'h5);
    err_clear = 1'b1; tick("an_err_clr"); err_clear = 1'b0;
    chk("an_err_clear", {31'h0, an_err}, 32'h0);

    // Illegal pattern on B, then blank on B
    hold(4'b1011, 7'b1010101, 20, "pat_err");
    chk("pattern_err_set", {31'h0, pattern_err}, 32'h1);
    hold(4'b1011, 7'b1111111, 20, "blank");
    chk("blank_B", {28'h0, digit_blank}, 32'h4);
    chk("blank_B_disp", {28'h0, displayB}, 32'h0);
    err_clear = 1'b1; tick("err_clr"); err_clear = 1'b0;

    // Driver emulation: 3-cycle ghost (new anode, old segments) then dwell
    dig[0] = 4'h1; dig[1] = 4'h2; dig[2] = 4'h3; dig[3] = 4'h4;
    f0 = frames;
    ps = 7'b1111111;
    for (int sc = 0; sc < 3; sc++) begin
      if (sc > 0) for (int d = 0; d < 4; d++) dig[d] = 4'($urandom_range(0, 15));
      for (int d = 0; d < 4; d++) begin
        pa = ~(4'b1 << d);
        hold(pa, ps, 3, "scan_ghost");
        ps = hex_pat[dig[d]];
        hold(pa, ps, 40, "scan_dwell");
      end
      if (sc == 0) begin
        chk("scan_disp", {16'h0, displayA, displayB, displayC, displayD}, 32'h4321);
        chk("scan_valid", {28'h0, digit_valid}, 32'hF);
        chk("scan_no_perr", {31'h0, pattern_err}, 32'h0);
      end
    end
    chk("scan_frames", frames - f0, 32'd3);

    // Display goes dark: two timeouts, TMO apart
    t0 = tmos;
    tmo_at.delete();
    hold(4'b1111, 7'b1111111, 2 * TMO, "timeout");
    chk("timeout_count", tmos - t0, 32'd2);
    if (tmo_at.size() == 2) chk("timeout_period", tmo_at[1] - tmo_at[0], TMO);
    chk("timeout_valid", {28'h0, digit_valid}, 32'h0);
    chk("timeout_disp_held", {16'h0, displayA, displayB, displayC, displayD},
        {16'h0, dig[3], dig[2], dig[1], dig[0]});

    // Randomized phase
    pa = 4'hF; ps = 7'h7F;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      ra = pa; rs = ps;
      case (k)
        0: begin ra = 4'hF; rs = 7'($urandom); end
        1, 2, 3, 4, 5: begin
          ra = ~(4'b1 << $urandom_range(0, 3));
          rs = hex_pat[$urandom_range(0, 15)];
        end
        6: begin ra = ~(4'b1 << $urandom_range(0, 3)); rs = 7'h7F; end
        7: begin
          ra = ~(4'b1 << $urandom_range(0, 3));
          do rs = 7'($urandom); while (decode(rs) >= 0 || rs == 7'h7F);
        end
        8: begin
          do ra = 4'($urandom); while ($countones(~ra) < 2);
          rs = 7'($urandom);
        end
        default: ;
      endcase
      pa = ra; ps = rs;
      bus.an = ra; bus.seg = rs;
      for (int c = $urandom_range(1, 30); c > 0; c--) begin
        err_clear = ($urandom_range(0, 9) == 0);
        tick("random");
      end
      err_clear = 1'b0;
    end

    // Reset in the middle of a dwell
    hold(4'b1101, 7'b0110000, 10, "mid_reset_pre");
    #7 reset_n = 1'b0;
    #1 chk("async_reset", {4'b0, dut_vec}, 32'h0);
    repeat (3) @(negedge clk_25MHz);
    reset_n = 1'b1;
    m_reset();
    hold(4'b1101, 7'b0110000, 17, "recapture");
    chk("recapture_early", {28'h0, displayC}, 32'h0);
    tick("recapture");
    chk("recapture_dispC", {28'h0, displayC}, 32'h3);
    chk("recapture_valid", {28'h0, digit_valid}, 32'h2);
    hold(4'b1101, 7'b0110000, 4, "recapture");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
